axis_demod_sched: RTL

- Per-frame scheduler in front of the selectable BPSK/QPSK/QAM16 demodulator.
- Software queues one modulation type per frame. The block applies each type only at frame boundaries and gates the 48-bit symbol stream into the demodulator.
- After the input tlast, it holds off the next frame until the demodulator's output tlast has drained, so demod_type never changes while a frame is in flight.
- Frames tagged with the invalid type 3 are consumed and dropped.

---
 rtl/axis_demod_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_demod_sched.sv
// Per-frame modulation scheduler: queues one demod type per frame, gates the symbol
// stream into the demodulator and waits for its output tlast before the next frame.
module axis_demod_sched #(
    parameter int QDEPTH    = 4,
    parameter int DRAIN_TMO = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [1:0]  cfg_type,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [47:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [47:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast,
    output logic [1:0]  demod_type,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [1:0]  err_sticky,
    input  logic        err_clr
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [15:0]   TMO_LAST = 16'(DRAIN_TMO - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PASS  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [1:0]    q_mem_r [QDEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] q_cnt_r;
    logic [CW-1:0] q_cnt_nxt_s;
    logic          cfg_ready_r;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    demod_type_r;
    logic [15:0]   tmo_cnt_r;
    logic [15:0]   frame_cnt_r;
    logic [1:0]    err_r;
    logic [1:0]    err_set_s;
    logic          tmo_clr_s;
    logic          frame_inc_s;
    logic          s_ready_s;
    logic          m_valid_s;
    logic          m_last_s;
    logic          mon_last_s;

    assign push_s     = cfg_valid & cfg_ready_r;
    assign mon_last_s = mon_tvalid & mon_tready & mon_tlast;

    // Next queue occupancy from push/pop
    always_comb begin
        q_cnt_nxt_s = q_cnt_r;
        case ({push_s, pop_s})
            2'b10:   q_cnt_nxt_s = q_cnt_r + CW'(1'b1);
            2'b01:   q_cnt_nxt_s = q_cnt_r - CW'(1'b1);
            default: q_cnt_nxt_s = q_cnt_r;
        endcase
    end

    // Type queue storage and pointers; cfg_ready is registered so it stays low in reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem_r[i] <= 2'd0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            q_cnt_r     <= '0;
            cfg_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                q_mem_r[wr_ptr_r] <= cfg_type;
                wr_ptr_r          <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            q_cnt_r     <= q_cnt_nxt_s;
            cfg_ready_r <= (q_cnt_nxt_s != FULL_CNT);
        end
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, stream gating and event strobes
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        tmo_clr_s   = 1'b0;
        frame_inc_s = 1'b0;
        err_set_s   = 2'b00;
        s_ready_s   = 1'b0;
        m_valid_s   = 1'b0;
        m_last_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (q_cnt_r != '0) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (demod_type_r == 2'd3) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_PASS: begin
                s_ready_s = m_axis_tready;
                m_valid_s = s_axis_tvalid;
                m_last_s  = s_axis_tlast;
                if (s_axis_tvalid & m_axis_tready & s_axis_tlast) begin
                    tmo_clr_s   = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_DRAIN: begin
                // A tlast arriving on the timeout cycle still counts as a clean finish
                if (mon_last_s) begin
                    frame_inc_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    err_set_s   = 2'b10;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DROP: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid & s_axis_tlast) begin
                    err_set_s   = 2'b01;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Type select, drain timer, frame counter and sticky errors
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            demod_type_r <= 2'd0;
            tmo_cnt_r    <= 16'd0;
            frame_cnt_r  <= 16'd0;
            err_r        <= 2'b00;
        end else begin
            if (pop_s) begin
                demod_type_r <= q_mem_r[rd_ptr_r];
            end
            if (tmo_clr_s) begin
                tmo_cnt_r <= 16'd0;
            end else if (state_r == ST_DRAIN) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
            if (frame_inc_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            err_r <= (err_clr ? 2'b00 : err_r) | err_set_s;
        end
    end

    assign cfg_ready     = cfg_ready_r;
    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = m_valid_s;
    assign m_axis_tlast  = m_last_s;
    assign demod_type    = demod_type_r;
    assign busy          = (state_r != ST_IDLE);
    assign frame_cnt     = frame_cnt_r;
    assign err_sticky    = err_r;

endmodule
